// File: rtl/hw_control_unit.sv
// rtl/hw_control_unit.sv - hardwired fetch/decode/execute control sequencer
//
// Ports:
//   clock, clear         rising-edge clock, synchronous active-high reset
//   IR[31:0]             instruction register from the datapath
//   mem_ready            memory read data valid (only looked at in T1)
//   Rin/Rout             one-hot register load / bus drive
//   PCin..HIin, LOin     datapath, Z, HI and LO strobes
//   IncPC, Read          PC increment, memory read
//   ALUop[3:0]           ALU operation select
//   Run                  high while sequencing instructions
//   illegal              one-cycle pulse on an undefined opcode
module hw_control_unit #(
    parameter int NUM_REGS = 16
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [31:0]         IR,
    input  logic                mem_ready,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                PCin,
    output logic                PCout,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zlowin,
    output logic                Zhighin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                Read,
    output logic [3:0]          ALUop,
    output logic                Run,
    output logic                illegal
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t state, state_nxt;
    // Set while T1 is repeating for memory; keeps PCin/Zlowout to the first T1 cycle.
    logic   t1_wait, t1_wait_nxt;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_alu3, is_muldiv, is_unary, is_nop, is_halt;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    assign is_alu3   = (opcode <= 5'd7);
    assign is_muldiv = (opcode == 5'd8)  || (opcode == 5'd9);
    assign is_unary  = (opcode == 5'd10) || (opcode == 5'd11);
    assign is_nop    = (opcode == 5'd26);
    assign is_halt   = (opcode == 5'd27);

    function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
        onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    always_ff @(posedge clock) begin
        if (clear) begin
            state   <= S_RESET;
            t1_wait <= 1'b0;
        end else begin
            state   <= state_nxt;
            t1_wait <= t1_wait_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        t1_wait_nxt = 1'b0;
        Rin         = '0;
        Rout        = '0;
        PCin        = 1'b0;
        PCout       = 1'b0;
        MARin       = 1'b0;
        MDRin       = 1'b0;
        MDRout      = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        Zlowin      = 1'b0;
        Zhighin     = 1'b0;
        Zlowout     = 1'b0;
        Zhighout    = 1'b0;
        HIin        = 1'b0;
        LOin        = 1'b0;
        IncPC       = 1'b0;
        Read        = 1'b0;
        ALUop       = 4'd0;
        illegal     = 1'b0;
        Run         = (state != S_RESET) && (state != S_HALT);

        case (state)
            S_RESET: state_nxt = S_T0;
            S_T0: begin
                PCout     = 1'b1;
                MARin     = 1'b1;
                IncPC     = 1'b1;
                Zlowin    = 1'b1;
                state_nxt = S_T1;
            end
            S_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                if (!t1_wait) begin
                    PCin    = 1'b1;
                    Zlowout = 1'b1;
                end
                if (mem_ready) state_nxt   = S_T2;
                else           t1_wait_nxt = 1'b1;
            end
            S_T2: begin
                MDRout    = 1'b1;
                IRin      = 1'b1;
                state_nxt = S_T3;
            end
            S_T3: begin
                if (is_alu3) begin
                    Rout      = onehot(rb);
                    Yin       = 1'b1;
                    state_nxt = S_T4;
                end else if (is_unary) begin
                    Rout      = onehot(rb);
                    ALUop     = opcode[3:0];
                    Zlowin    = 1'b1;
                    state_nxt = S_T4;
                end else if (is_muldiv) begin
                    Rout      = onehot(ra);
                    Yin       = 1'b1;
                    state_nxt = S_T4;
                end else if (is_nop) begin
                    state_nxt = S_T0;
                end else if (is_halt) begin
                    state_nxt = S_HALT;
                end else begin
                    illegal   = 1'b1;
                    state_nxt = S_T0;
                end
            end
            S_T4: begin
                state_nxt = S_T0;
                if (is_alu3) begin
                    Rout      = onehot(rc);
                    ALUop     = opcode[3:0];
                    Zlowin    = 1'b1;
                    state_nxt = S_T5;
                end else if (is_unary) begin
                    Zlowout = 1'b1;
                    Rin     = onehot(ra);
                end else if (is_muldiv) begin
                    Rout      = onehot(rb);
                    ALUop     = opcode[3:0];
                    Zlowin    = 1'b1;
                    Zhighin   = 1'b1;
                    state_nxt = S_T5;
                end
            end
            S_T5: begin
                state_nxt = S_T0;
                if (is_alu3) begin
                    Zlowout = 1'b1;
                    Rin     = onehot(ra);
                end else if (is_muldiv) begin
                    Zlowout   = 1'b1;
                    LOin      = 1'b1;
                    state_nxt = S_T6;
                end
            end
            S_T6: begin
                Zhighout  = 1'b1;
                HIin      = 1'b1;
                state_nxt = S_T0;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_hw_control_unit.sv
// tb/tb_hw_control_unit.sv - scoreboard bench for hw_control_unit
module tb_hw_control_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        mem_ready = 1'b1;
    logic [31:0] IR = 32'd0;

    logic [15:0] Rin, Rout;
    logic PCin, PCout, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin;
    logic Zlowout, Zhighout, HIin, LOin, IncPC, Read, Run, illegal;
    logic [3:0] ALUop;

    hw_control_unit #(.NUM_REGS(16)) dut (
        .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
        .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .IncPC(IncPC),
        .Read(Read), .ALUop(ALUop), .Run(Run), .illegal(illegal)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic pcin, pcout, marin, mdrin, mdrout, irin, yin, zlowin, zhighin;
        logic zlowout, zhighout, hiin, loin, incpc, read;
        logic [3:0] aluop;
        logic run, illegal;
    } outs_t;

    outs_t act;
    assign act = {Rin, Rout, PCin, PCout, MARin, MDRin, MDRout, IRin, Yin,
                  Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, IncPC,
                  Read, ALUop, Run, illegal};

    outs_t exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad = 0;

    outs_t mon_e;
    string mon_n;
    int    drivers;

    // Monitor: one expected record per clock cycle, compared mid-cycle.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            total++;
            if (act !== mon_e) begin
                bad++;
                $display("FAIL %s: outputs got %h expected %h", mon_n, act, mon_e);
            end
            total++;
            if ($countones(Rin) > 1 || $countones(Rout) > 1) begin
                bad++;
                $display("FAIL %s_onehot: Rin=%h Rout=%h expected at most one bit each", mon_n, Rin, Rout);
            end
            drivers = int'(Rout != 16'd0) + int'(PCout) + int'(MDRout) + int'(Zlowout) + int'(Zhighout);
            total++;
            if (drivers > 1) begin
                bad++;
                $display("FAIL %s_bus: %0d bus drivers expected at most 1", mon_n, drivers);
            end
        end
    end

    // Reference plan: list of per-cycle expected outputs and mem_ready values.
    outs_t plan_e[$];
    logic  plan_mr[$];
    string plan_n[$];

    function automatic outs_t running();
        outs_t o = '0;
        o.run = 1'b1;
        return o;
    endfunction

    task automatic add(input outs_t o, input logic mr, input string n);
        plan_e.push_back(o);
        plan_mr.push_back(mr);
        plan_n.push_back(n);
    endtask

    task automatic plan_instr(input logic [31:0] ir, input int waits);
        outs_t o;
        logic [4:0] op;
        logic [15:0] ra_oh, rb_oh, rc_oh;
        op    = ir[31:27];
        ra_oh = 16'd1 << ir[26:23];
        rb_oh = 16'd1 << ir[22:19];
        rc_oh = 16'd1 << ir[18:15];
        plan_e.delete(); plan_mr.delete(); plan_n.delete();

        o = running(); o.pcout = 1; o.marin = 1; o.incpc = 1; o.zlowin = 1;
        add(o, 1'($urandom), "T0");
        o = running(); o.zlowout = 1; o.pcin = 1; o.read = 1; o.mdrin = 1;
        add(o, waits == 0, "T1");
        for (int i = 0; i < waits; i++) begin
            o = running(); o.read = 1; o.mdrin = 1;
            add(o, i == waits - 1, "T1wait");
        end
        o = running(); o.mdrout = 1; o.irin = 1;
        add(o, 1'($urandom), "T2");

        if (op <= 5'd7) begin
            o = running(); o.rout = rb_oh; o.yin = 1;                         add(o, 1'($urandom), "alu_T3");
            o = running(); o.rout = rc_oh; o.aluop = op[3:0]; o.zlowin = 1;   add(o, 1'($urandom), "alu_T4");
            o = running(); o.zlowout = 1; o.rin = ra_oh;                      add(o, 1'($urandom), "alu_T5");
        end else if (op == 5'd8 || op == 5'd9) begin
            o = running(); o.rout = ra_oh; o.yin = 1;                         add(o, 1'($urandom), "md_T3");
            o = running(); o.rout = rb_oh; o.aluop = op[3:0]; o.zlowin = 1; o.zhighin = 1;
            add(o, 1'($urandom), "md_T4");
            o = running(); o.zlowout = 1; o.loin = 1;                         add(o, 1'($urandom), "md_T5");
            o = running(); o.zhighout = 1; o.hiin = 1;                        add(o, 1'($urandom), "md_T6");
        end else if (op == 5'd10 || op == 5'd11) begin
            o = running(); o.rout = rb_oh; o.aluop = op[3:0]; o.zlowin = 1;   add(o, 1'($urandom), "un_T3");
            o = running(); o.zlowout = 1; o.rin = ra_oh;                      add(o, 1'($urandom), "un_T4");
        end else if (op == 5'd26 || op == 5'd27) begin
            add(running(), 1'($urandom), "nop_halt_T3");
        end else begin
            o = running(); o.illegal = 1;                                     add(o, 1'($urandom), "ill_T3");
        end
    endtask

    task automatic drive(input logic c, input logic mr, input logic [31:0] ir,
                         input outs_t e, input string n);
        @(posedge clock);
        #1;
        clear     = c;
        mem_ready = mr;
        IR        = ir;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    // Runs one instruction from T0; abort_at >= 0 raises clear in that step.
    task automatic run_instr(input logic [31:0] ir, input int waits, input int abort_at);
        plan_instr(ir, waits);
        for (int i = 0; i < plan_e.size(); i++) begin
            if (i == abort_at) begin
                drive(1'b1, plan_mr[i], ir, plan_e[i], {plan_n[i], "_abort"});
                drive(1'b0, 1'b1, ir, '0, "reset_after_abort");
                return;
            end
            drive(1'b0, plan_mr[i], ir, plan_e[i], plan_n[i]);
        end
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] ir;
        int          waits, ab;

        drive(1'b1, 1'b1, 32'd0, '0, "reset_1");
        drive(1'b0, 1'b1, 32'd0, '0, "reset_2");

        run_instr(32'h52380000, 0, -1);   // NEG R4, R7
        run_instr(32'h01A20000, 0, -1);   // ADD R3, R4, R4
        run_instr(32'h41180000, 0, -1);   // MUL R2, R3
        run_instr(32'h01A20000, 3, -1);   // memory stall in T1
        run_instr(32'hA0000000, 0, -1);   // opcode 20, illegal
        run_instr(32'hD0000000, 1, -1);   // NOP
        run_instr(32'h01A20000, 0, 4);    // clear in T4

        for (int n = 0; n < 40; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            ir    = {op, 27'($urandom)};
            waits = $urandom_range(0, 3);
            ab    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1;
            run_instr(ir, waits, ab);
        end

        run_instr(32'hD8000000, 0, -1);   // HALT
        for (int i = 0; i < 20; i++)
            drive(1'b0, 1'($urandom), 32'hD8000000, '0, "halt_hold");
        drive(1'b1, 1'b1, 32'hD8000000, '0, "halt_clear");
        drive(1'b0, 1'b1, 32'd0, '0, "reset_after_halt");
        run_instr(32'h41180000 | 32'h08000000, 2, -1);   // DIV after restart

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clock);
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
